// File: rtl/mem_arb_pkg.sv
`default_nettype none
// mem_arb_pkg -- widths and state/owner types shared by the memory arbiter, main memory and CPU.
// Rev 1.0
package mem_arb_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int RUN_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// mem_arb_pick -- data-priority winner selection with a fetch starvation guard.
// Rev 1.0
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [RUN_W-1:0] run;
  logic             run_full;

  // Once data has won MAX_D_RUN contested rounds, a waiting fetch goes first.
  assign run_full = (run == RUN_MAX);
  assign grant_d  = en && d_req && (!i_req || !run_full);
  assign grant_i  = en && i_req && !grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= '0;
    end else if (grant_i) begin
      run <= '0;
    end else if (grant_d && i_req && !run_full) begin
      run <= run + RUN_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter -- shares single-port main memory between instruction fetch and data ports.
// Rev 1.0
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = mem_arb_pkg::ADDR_W,
  parameter int DATA_W    = mem_arb_pkg::DATA_W,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  state_t state;
  owner_t owner;
  logic   grant_i;
  logic   grant_d;

  mem_arb_pick #(
    .MAX_D_RUN (MAX_D_RUN)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .en      (state == IDLE),
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // State sits in IDLE during reset, so the grant pulses are masked explicitly.
  assign i_gnt = grant_i && !rst;
  assign d_gnt = grant_d && !rst;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= FETCH;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (grant_d) begin
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            owner     <= DATA;
            state     <= ACCESS;
          end else if (grant_i) begin
            mem_addr <= i_addr;
            owner    <= FETCH;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (mem_we) begin
            state <= IDLE;
          end else begin
            // Memory drives the read word late in ACCESS; capture it so valid and rdata align.
            state <= RESP;
            if (owner == DATA) begin
              d_rdata <= mem_rd_data;
              d_valid <= 1'b1;
            end else begin
              i_rdata <= mem_rd_data;
              i_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port main memory (22-bit word address, 32-bit data, one access per cycle) between two requesters: the CPU instruction-fetch port and the data (load/store) port.
- Sequences each access into a fixed address/write phase followed by a read-return phase.
- Arbitrates with data priority plus a starvation guard for fetch.
- Sits between the CPU pipeline and main memory; it is the only driver of the memory's addr/we/wdata inputs.

Parameters:
- ADDR_W, 22, word address width (matches main memory depth 2**22).
- DATA_W, 32, data width.
- MAX_D_RUN, 4, max consecutive contested data grants before a pending fetch is forced through (range 1..15).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  ADDR_W  fetch word address.
- i_gnt  out  1  fetch request accepted (1-cycle pulse).
- i_valid  out  1  i_rdata valid (1-cycle pulse).
- i_rdata  out  DATA_W  fetched word; holds until the next fetch return.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted (1-cycle pulse).
- d_valid  out  1  d_rdata valid (loads only, 1-cycle pulse).
- d_rdata  out  DATA_W  load data; holds until the next load return.
- mem_addr  out  ADDR_W  to main memory addr (registered).
- mem_we  out  1  to main memory we (registered).
- mem_wdata  out  DATA_W  to main memory wdata (registered).
- mem_rd_data  in  DATA_W  from main memory rd_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:

Reset values (asynchronous; take effect immediately on rst):
- state = IDLE.
- All gnt/valid = 0, mem_we = 0, busy = 0.
- mem_addr, mem_wdata, i_rdata, d_rdata = 0.
- run counter = 0.
- owner = FETCH.

FSM states:
- IDLE: grants are issued only here. The gnt pulse is combinational in cycle N, from req and the arbitration decision.
  - At the edge ending cycle N: mem_addr <= winner address; mem_we <= (winner is data && d_we); mem_wdata <= d_wdata (data) or hold (fetch); owner latched; go to ACCESS.
  - No req: remain in IDLE; mem_we = 0; mem_addr holds.
- ACCESS (cycle N+1): mem_* stable for the whole cycle. Main memory samples addr/we on this clock-high phase.
  - Write: next state IDLE; mem_we cleared at the end of N+1. Exactly one cycle of mem_we per store.
  - Read: next state RESP; mem_we stays 0.
- RESP (cycle N+2): mem_rd_data is valid.
  - owner FETCH: i_rdata <= mem_rd_data, i_valid pulses in N+2.
  - owner DATA: d_rdata <= mem_rd_data, d_valid pulses in N+2.
  - Next state IDLE.
  - The valid pulse and the registered rdata are aligned: rdata is updated at the N+1/N+2 edge.

Latency and throughput:
- Read: gnt-to-valid = 2 cycles; a new grant is possible in cycle N+3.
- Write: a new grant is possible in N+2.
- Peak throughput: 1 read / 3 cycles or 1 write / 2 cycles.

Arbitration (evaluated in IDLE only):
- Only one req: grant it.
- Both reqs: grant data unless run == MAX_D_RUN, in which case grant fetch.
- run counter:
  - Increments on each data grant made while i_req = 1.
  - Clears on any fetch grant.
  - Saturates at MAX_D_RUN.
  - Uncontested data grants leave it unchanged.

Boundary conditions:
- A req dropped before gnt is a protocol violation. The arbiter does not track it; behaviour is defined only by the current req.
- A req asserted during ACCESS/RESP waits; no gnt until IDLE.
- The requester that was just served may re-request immediately and is arbitrated normally in IDLE.
- Reset during ACCESS (write): mem_we drops immediately; no further write. The memory word may or may not be written; the bench must not check it.
- Reset during ACCESS/RESP (read): the read is dropped; no valid is issued.
- Address width is exact; no wrap or bounds check (full 2**22 space).

Decomposition:
- Package mem_arb_pkg:
  - State enum {IDLE, ACCESS, RESP}.
  - Owner enum {FETCH, DATA}.
  - ADDR_W/DATA_W constants shared with the memory and CPU.
- Sub-module mem_arb_pick:
  - Combinational winner selection plus the registered run counter.
  - Inputs i_req, d_req, an enable (state == IDLE), clk, rst.
  - Outputs grant_i, grant_d.
- The FSM, the mem_* registers and the return registers stay in mem_arbiter.

Test Plan:
- Memory preloaded with mem[0x000010] = 0xDEADBEEF; i_req with i_addr = 0x10 → i_gnt in cycle 0; mem_we = 0 throughout; i_valid in cycle 2 with i_rdata = 0xDEADBEEF; busy high in cycles 1–2.
- Store d_we = 1, d_addr = 0x3FFFFF, d_wdata = 0x12345678 → exactly one cycle of mem_we with mem_addr = 0x3FFFFF; then a load of 0x3FFFFF → d_valid 2 cycles after d_gnt with d_rdata = 0x12345678; i_valid stays 0.
- i_req and d_req both held high continuously, all loads, MAX_D_RUN = 4 → grant order D, D, D, D, I, D, D, D, D, I; grants spaced 3 cycles apart; each valid goes to the correct port.
- Simultaneous i_req and store with run = 0 → d_gnt first; i_gnt exactly 2 cycles later; i_rdata unchanged until its own return.
- Assert rst mid-cycle during a write ACCESS → mem_we, busy and gnts go 0 immediately; after release, state is IDLE and the next req is granted in its first cycle.
- Idle 20 cycles with no req → mem_we = 0 and busy = 0 throughout; no gnt or valid pulses; mem_addr holds its last value.
